// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : MIPS Decode stage. IF/ID register, bypassed register file,
//            control decode and early branch/jump resolution.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallD,
   input  logic        flushD,
   input  logic [31:0] instrF,
   input  logic [31:0] pcplus4F,
   input  logic        regwriteW,
   input  logic [4:0]  writeregW,
   input  logic [31:0] resultW,
   input  logic        forwardAD,
   input  logic        forwardBD,
   input  logic [31:0] aluoutM,
   output logic [31:0] rd1D,
   output logic [31:0] rd2D,
   output logic [31:0] signimmD,
   output logic [4:0]  rsD,
   output logic [4:0]  rtD,
   output logic [4:0]  rdD,
   output logic        pcsrcD,
   output logic [31:0] pcbranchD,
   output logic [31:0] pcjumpD,
   output logic [1:0]  branchD,
   output logic        jumpD,
   output logic [7:0]  ctrlD
);

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   localparam logic [5:0] c_FN_ADD = 6'b100000;
   localparam logic [5:0] c_FN_SUB = 6'b100010;
   localparam logic [5:0] c_FN_AND = 6'b100100;
   localparam logic [5:0] c_FN_OR  = 6'b100101;
   localparam logic [5:0] c_FN_SLT = 6'b101010;

   logic [31:0] instr_q, instr_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic [31:0] rf_q [32];

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [31:0] w_cmp_a;
   logic [31:0] w_cmp_b;

   // Stall outranks flush so a stalled bubble cannot overwrite a held instruction
   always_comb begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      if (!stallD) begin
         if (flushD) begin
            instr_d   = '0;
            pcplus4_d = '0;
         end else begin
            instr_d   = instrF;
            pcplus4_d = pcplus4F;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q   <= '0;
         pcplus4_q <= '0;
      end else begin
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (regwriteW && (writeregW != 5'd0)) begin
         rf_q[writeregW] <= resultW;
      end
   end

   assign rsD      = instr_q[25:21];
   assign rtD      = instr_q[20:16];
   assign rdD      = instr_q[15:11];
   assign w_op     = instr_q[31:26];
   assign w_funct  = instr_q[5:0];
   assign signimmD = {{16{instr_q[15]}}, instr_q[15:0]};

   // Same-cycle write-back is visible to the reader
   always_comb begin
      rd1D = rf_q[rsD];
      rd2D = rf_q[rtD];
      if (rsD == 5'd0) begin
         rd1D = '0;
      end else if (regwriteW && (writeregW == rsD)) begin
         rd1D = resultW;
      end
      if (rtD == 5'd0) begin
         rd2D = '0;
      end else if (regwriteW && (writeregW == rtD)) begin
         rd2D = resultW;
      end
   end

   // ctrlD = {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol[2:0]}
   always_comb begin
      ctrlD   = 8'h00;
      branchD = 2'b00;
      jumpD   = 1'b0;
      case (w_op)
         c_OP_RTYPE: begin
            case (w_funct)
               c_FN_ADD: ctrlD = 8'b1000_1010;
               c_FN_SUB: ctrlD = 8'b1000_1110;
               c_FN_AND: ctrlD = 8'b1000_1000;
               c_FN_OR:  ctrlD = 8'b1000_1001;
               c_FN_SLT: ctrlD = 8'b1000_1111;
               default:  ctrlD = 8'h00;
            endcase
         end
         c_OP_LW:   ctrlD = 8'b1101_0010;
         c_OP_SW:   ctrlD = 8'b0011_0010;
         c_OP_ADDI: ctrlD = 8'b1001_0010;
         c_OP_BEQ: begin
            ctrlD   = 8'b0000_0110;
            branchD = 2'b01;
         end
         c_OP_BNE: begin
            ctrlD   = 8'b0000_0110;
            branchD = 2'b10;
         end
         c_OP_J:    jumpD = 1'b1;
         default: begin
            ctrlD   = 8'h00;
            branchD = 2'b00;
            jumpD   = 1'b0;
         end
      endcase
   end

   assign w_cmp_a = forwardAD ? aluoutM : rd1D;
   assign w_cmp_b = forwardBD ? aluoutM : rd2D;

   assign pcsrcD    = (branchD[0] & (w_cmp_a == w_cmp_b)) |
                      (branchD[1] & (w_cmp_a != w_cmp_b));
   assign pcbranchD = pcplus4_q + {signimmD[29:0], 2'b00};
   assign pcjumpD   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage using a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallD, flushD;
   logic [31:0] instrF, pcplus4F;
   logic        regwriteW;
   logic [4:0]  writeregW;
   logic [31:0] resultW;
   logic        forwardAD, forwardBD;
   logic [31:0] aluoutM;
   logic [31:0] rd1D, rd2D, signimmD, pcbranchD, pcjumpD;
   logic [4:0]  rsD, rtD, rdD;
   logic        pcsrcD, jumpD;
   logic [1:0]  branchD;
   logic [7:0]  ctrlD;

   decode_stage dut (
      .clk(clk), .reset(reset), .stallD(stallD), .flushD(flushD),
      .instrF(instrF), .pcplus4F(pcplus4F), .regwriteW(regwriteW),
      .writeregW(writeregW), .resultW(resultW), .forwardAD(forwardAD),
      .forwardBD(forwardBD), .aluoutM(aluoutM), .rd1D(rd1D), .rd2D(rd2D),
      .signimmD(signimmD), .rsD(rsD), .rtD(rtD), .rdD(rdD), .pcsrcD(pcsrcD),
      .pcbranchD(pcbranchD), .pcjumpD(pcjumpD), .branchD(branchD),
      .jumpD(jumpD), .ctrlD(ctrlD)
   );

   always #5 clk = ~clk;

   localparam int c_RD1 = 0, c_RD2 = 1, c_IMM = 2, c_RS = 3, c_RT = 4,
                  c_RD = 5, c_PCSRC = 6, c_PCBR = 7, c_PCJ = 8, c_BR = 9,
                  c_J = 10, c_CTRL = 11;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         c_RD1:   return rd1D;
         c_RD2:   return rd2D;
         c_IMM:   return signimmD;
         c_RS:    return {27'd0, rsD};
         c_RT:    return {27'd0, rtD};
         c_RD:    return {27'd0, rdD};
         c_PCSRC: return {31'd0, pcsrcD};
         c_PCBR:  return pcbranchD;
         c_PCJ:   return pcjumpD;
         c_BR:    return {30'd0, branchD};
         c_J:     return {31'd0, jumpD};
         default: return {24'd0, ctrlD};
      endcase
   endfunction

   task automatic expect_v(input string tag, input int sel, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.sel = sel;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check_all();
      exp_t        x;
      logic [31:0] o;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         o = observe(x.sel);
         vectors++;
         assert (o === x.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stallD = 1'b0; flushD = 1'b0;
      instrF = '0; pcplus4F = '0;
      regwriteW = 1'b0; writeregW = '0; resultW = '0;
      forwardAD = 1'b0; forwardBD = 1'b0; aluoutM = '0;
      step(); step();
      expect_v("rst_rd1", c_RD1, 32'h0);
      expect_v("rst_ctrl", c_CTRL, 32'h0);
      expect_v("rst_pcbr", c_PCBR, 32'h0);
      expect_v("rst_pcj", c_PCJ, 32'h0);
      expect_v("rst_imm", c_IMM, 32'h0);
      check_all();
      reset = 1'b0;

      // load r8 = r9 = 5 through write-back
      regwriteW = 1'b1; writeregW = 5'd8; resultW = 32'h5;
      step();
      writeregW = 5'd9;
      step();
      regwriteW = 1'b0;

      // beq $8,$9,+3
      instrF = 32'h11090003; pcplus4F = 32'h100;
      step();
      expect_v("beq_pcsrc", c_PCSRC, 32'h1);
      expect_v("beq_pcbr", c_PCBR, 32'h10C);
      expect_v("beq_br", c_BR, 32'h1);
      expect_v("beq_ctrl", c_CTRL, 32'h06);
      expect_v("beq_rd1", c_RD1, 32'h5);
      expect_v("beq_rd2", c_RD2, 32'h5);
      expect_v("beq_rs", c_RS, 32'd8);
      expect_v("beq_rt", c_RT, 32'd9);
      check_all();

      // bne $8,$9,-1
      instrF = 32'h1509FFFF;
      step();
      expect_v("bne_pcsrc", c_PCSRC, 32'h0);
      expect_v("bne_pcbr", c_PCBR, 32'h0FC);
      expect_v("bne_br", c_BR, 32'h2);
      check_all();
      forwardAD = 1'b1; aluoutM = 32'h7;
      #1;
      expect_v("bne_fwdA", c_PCSRC, 32'h1);
      check_all();
      forwardAD = 1'b0;
      forwardBD = 1'b1;
      #1;
      expect_v("bne_fwdB", c_PCSRC, 32'h1);
      check_all();
      forwardBD = 1'b0;

      // beq target wraps past 2^32
      instrF = 32'h11090001; pcplus4F = 32'hFFFFFFFC;
      step();
      expect_v("wrap_pcbr", c_PCBR, 32'h0);
      expect_v("wrap_pcsrc", c_PCSRC, 32'h1);
      check_all();

      // add $10,$8,$0 with same-cycle write to r8
      instrF = 32'h01005020; pcplus4F = 32'h200;
      step();
      regwriteW = 1'b1; writeregW = 5'd8; resultW = 32'hDEADBEEF;
      #1;
      expect_v("byp_rd1", c_RD1, 32'hDEADBEEF);
      expect_v("add_ctrl", c_CTRL, 32'h8A);
      expect_v("add_rd", c_RD, 32'd10);
      check_all();
      writeregW = 5'd0; resultW = 32'h12345678;
      #1;
      expect_v("r0_byp_rd2", c_RD2, 32'h0);
      expect_v("r0_byp_rd1", c_RD1, 32'h5);
      check_all();
      step();
      regwriteW = 1'b0;
      #1;
      expect_v("r0_write_rd2", c_RD2, 32'h0);
      expect_v("r8_array", c_RD1, 32'h5);
      check_all();

      // unsupported funct decodes to no controls
      instrF = 32'h01005021;
      step();
      expect_v("addu_ctrl", c_CTRL, 32'h0);
      check_all();

      instrF = 32'h01005020;
      step();
      // stall wins over flush
      instrF = 32'h8D090004; stallD = 1'b1; flushD = 1'b1;
      step();
      expect_v("stall_ctrl", c_CTRL, 32'h8A);
      expect_v("stall_rd", c_RD, 32'd10);
      check_all();
      stallD = 1'b0;
      step();
      expect_v("flush_ctrl", c_CTRL, 32'h0);
      expect_v("flush_br", c_BR, 32'h0);
      expect_v("flush_j", c_J, 32'h0);
      expect_v("flush_pcbr", c_PCBR, 32'h0);
      check_all();
      flushD = 1'b0;

      // j with upper PC bits preserved
      instrF = 32'h08000040; pcplus4F = 32'hF0000004;
      step();
      expect_v("j_jump", c_J, 32'h1);
      expect_v("j_pcj", c_PCJ, 32'hF0000100);
      expect_v("j_ctrl", c_CTRL, 32'h0);
      check_all();

      // lw $9,4($8)
      instrF = 32'h8D090004; pcplus4F = 32'h300;
      step();
      expect_v("lw_ctrl", c_CTRL, 32'hD2);
      expect_v("lw_imm", c_IMM, 32'h4);
      expect_v("lw_rt", c_RT, 32'd9);
      expect_v("lw_rd1", c_RD1, 32'h5);
      check_all();

      // asynchronous reset between clock edges
      #2;
      reset = 1'b1;
      #1;
      expect_v("arst_rs", c_RS, 32'd0);
      expect_v("arst_rd1", c_RD1, 32'h0);
      expect_v("arst_imm", c_IMM, 32'h0);
      expect_v("arst_ctrl", c_CTRL, 32'h0);
      check_all();
      step();
      reset = 1'b0;
      instrF = 32'h01005020;
      step();
      expect_v("post_rst_r8", c_RD1, 32'h0);
      check_all();
      instrF = 32'h11090003;
      step();
      expect_v("post_rst_r9", c_RD2, 32'h0);
      check_all();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name:
decode_stage

Overview:
MIPS pipeline Decode stage, directly downstream of Fetch. Contains the IF/ID pipeline register with stall/flush, a 32x32 register file with write-back bypass, the main/ALU control decoder, and early branch/jump resolution. Feeds pcsrcD/branchD/pcbranchD/pcjumpD back to Fetch's PC select and operands/controls forward to ID/EX.

Parameters:
none; datapath fixed at 32 bits, 32 architectural registers.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears IF/ID register and all registers
stallD  in  1  hold IF/ID register contents
flushD  in  1  load bubble (all zeros) into IF/ID register
instrF  in  32  instruction from Fetch
pcplus4F  in  32  PC+4 from Fetch
regwriteW  in  1  write-back enable
writeregW  in  5  write-back destination register
resultW  in  32  write-back data
forwardAD  in  1  branch comparator operand A takes aluoutM
forwardBD  in  1  branch comparator operand B takes aluoutM
aluoutM  in  32  Memory-stage ALU result for branch forwarding
rd1D  out  32  register rs value (bypassed)
rd2D  out  32  register rt value (bypassed)
signimmD  out  32  sign-extended instrD[15:0]
rsD  out  5  instrD[25:21]
rtD  out  5  instrD[20:16]
rdD  out  5  instrD[15:11]
pcsrcD  out  1  branch taken
pcbranchD  out  32  branch target
pcjumpD  out  32  jump target
branchD  out  2  bit0 = beq, bit1 = bne
jumpD  out  1  j instruction
ctrlD  out  8  {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol[2:0]}

Behaviour:
- IF/ID register (instrD, pcplus4D): reset -> 0. Else on clk: stallD=1 holds (stall has priority over flush); else flushD=1 loads 0; else loads instrF/pcplus4F. One-cycle latency: instruction at instrF in cycle n is decoded in cycle n+1.
- All outputs are combinational from instrD/pcplus4D/regfile. With instrD=0: every output except rd1D/rd2D/pcbranchD/pcjumpD is 0; rd1D/rd2D = 0 (r0). pcbranchD = pcplus4D; pcjumpD = {pcplus4D[31:28], 28'b0}.
- Register file: reset clears all 32 entries to 0. Write on clk when regwriteW=1 and writeregW!=0. r0 reads 0 always. Read bypass: rd1D = resultW when regwriteW=1, writeregW==rsD and rsD!=0, else the array value; rd2D likewise with rtD.
- Decoder, op = instrD[31:26]:
  R-type 000000 with funct add 100000 / sub 100010 / and 100100 / or 100101 / slt 101010 -> regwrite=1, regdst=1, alucontrol 010/110/000/001/111. Any other funct -> ctrl=0.
  lw 100011 -> regwrite, memtoreg, alusrc, alu 010.
  sw 101011 -> memwrite, alusrc, alu 010.
  addi 001000 -> regwrite, alusrc, alu 010.
  beq 000100 -> branchD=01, alu 110. bne 000101 -> branchD=10, alu 110.
  j 000010 -> jumpD=1. Any other opcode -> all controls 0.
- Branch compare: A = forwardAD ? aluoutM : rd1D; B = forwardBD ? aluoutM : rd2D. pcsrcD = (branchD[0] & A==B) | (branchD[1] & A!=B).
- pcbranchD = pcplus4D + (signimmD << 2), modulo 2^32 (wraps). pcjumpD = {pcplus4D[31:28], instrD[25:0], 2'b00}.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge; outputs take their bubble values.

Test Plan:
- Reset, then write r8=0x00000005 and r9=0x00000005 via W; decode beq $8,$9,+3 (0x11090003) with pcplus4F=0x100 -> pcsrcD=1, pcbranchD=0x10C, branchD=01.
- Same operands, bne $8,$9,-1 (0x1509FFFF), pcplus4=0x100 -> pcsrcD=0, pcbranchD=0x0FC; set forwardAD=1 with aluoutM=7 -> pcsrcD=1.
- Write-bypass: regwriteW=1, writeregW=8, resultW=0xDEADBEEF in the same cycle add $10,$8,$0 is in D -> rd1D=0xDEADBEEF, ctrlD=0x8A. Write to r0 -> rd of $0 stays 0.
- stallD=1 and flushD=1 together -> instrD held; next cycle flushD=1 alone -> ctrlD=0, branchD=0, jumpD=0.
- j 0x0000040 (0x08000040) with pcplus4=0xF0000004 -> jumpD=1, pcjumpD=0xF0000100; lw (0x8D090004) -> ctrlD=0xD2, signimmD=4.
- Assert reset asynchronously mid-stream -> instrD=0 and rd1D=0 before the next edge; all registers read 0 afterwards.
